// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small TX FIFO.
// CPU stores to DATA_ADDR queue bytes, which go out 8N1, LSB first, on txd.
// A load from STAT_ADDR returns {5'b0, overflow, full, busy} on rd_data.
// A store to STAT_ADDR clears the sticky overflow flag.
// Define MMIO_UART_TX_PARITY_EN to send 8E1 frames (even parity bit).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   address, wr_data  CPU data address and store data
//   we                store strobe (level; one push per rising edge)
//   rd_data, sel_o    status word and read-mux select (combinational)
//   txd               serial line, idle high
//   busy              FIFO non-empty or frame in flight
module mmio_uart_tx #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         BAUD       = 115200,
    parameter logic [7:0] DATA_ADDR  = 8'hFE,
    parameter logic [7:0] STAT_ADDR  = 8'hFD,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic [7:0] wr_data,
    input  logic       we,
    output logic [7:0] rd_data,
    output logic       sel_o,
    output logic       txd,
    output logic       busy
);

    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(BIT_DIV);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       idx_q, idx_n;
    logic [7:0]       shift_q, shift_n;
    logic             txd_n;
`ifdef MMIO_UART_TX_PARITY_EN
    logic             par_q, par_n;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             overflow;
    logic             we_q;

    logic accept;
    logic hit_data;
    logic hit_stat;
    logic full;
    logic push;
    logic pop;
    logic bit_end;

    // One push per strobe: only the first cycle of a held we counts.
    assign accept   = we && !we_q;
    assign hit_data = accept && (address == DATA_ADDR);
    assign hit_stat = accept && (address == STAT_ADDR);

    // Full is judged on the pre-cycle count, so a same-cycle pop
    // does not make room for a push.
    assign full = (count_q == FULL_CNT);
    assign push = hit_data && !full;

    assign busy    = (state_q != IDLE) || (count_q != '0);
    assign sel_o   = (address == STAT_ADDR);
    assign rd_data = sel_o ? {5'b0, overflow, full, busy} : 8'h00;

    assign bit_end = (cnt_q == BIT_LAST);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        pop     = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_n = '0;
                // Pop uses the registered count: a byte pushed this
                // cycle into an empty FIFO leaves on the next one.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
`ifdef MMIO_UART_TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    idx_n   = 3'd0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift_q >> 1;
                    idx_n   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // txd is registered from the next state so the line never glitches.
    always_comb begin
        txd_n = 1'b1;
        unique case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY:  txd_n = par_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            txd     <= txd_n;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            we_q <= we;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (hit_data && full) begin
                overflow <= 1'b1;
            end else if (hit_stat) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule
